// File: rtl/key_pkg.sv
// Shared definitions for the decimal key debouncer: key count, FSM encodings
// and the single-key test used to qualify a candidate press.
package key_pkg;

   localparam int N_KEYS = 10;

   typedef enum logic [1:0] {
      ST_IDLE          = 2'd0,
      ST_CHECK_PRESS   = 2'd1,
      ST_HELD          = 2'd2,
      ST_CHECK_RELEASE = 2'd3
   } state_t;

   function automatic logic is_onehot10(input logic [N_KEYS-1:0] v);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < N_KEYS; i++) begin
         ones = ones + {31'b0, v[i]};
      end
      return (ones == 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing asynchronous button levels into the clk domain.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/key_debounce_onehot.sv
// Debounces ten decimal push-buttons into a stable one-hot key vector with a
// single-cycle strobe on each accepted press.
module key_debounce_onehot
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] btn,
   output logic [N_KEYS-1:0] key_out,
   output logic              key_valid,
   output logic              key_pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] s;

   state_t            state_q,     state_d;
   logic [CNT_W-1:0]  cnt_q,       cnt_d;
   logic [N_KEYS-1:0] cand_q,      cand_d;
   logic [N_KEYS-1:0] key_out_q,   key_out_d;
   logic              key_valid_q, key_valid_d;
   logic              key_pulse_q, key_pulse_d;

   sync_2ff #(.WIDTH(N_KEYS)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn),
      .q     (s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cand_d      = cand_q;
      key_out_d   = key_out_q;
      key_pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            key_out_d = '0;
            if (is_onehot10(s)) begin
               cand_d  = s;
               cnt_d   = '0;
               state_d = ST_CHECK_PRESS;
            end
         end
         ST_CHECK_PRESS: begin
            if (s != cand_q) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d       = '0;
               key_out_d   = cand_q;
               key_pulse_d = 1'b1;
               state_d     = ST_HELD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            // Extra keys pressed alongside the held one are ignored.
            if ((s & cand_q) == '0) begin
               cnt_d   = '0;
               state_d = ST_CHECK_RELEASE;
            end
         end
         ST_CHECK_RELEASE: begin
            if ((s & cand_q) != '0) begin
               cnt_d   = '0;
               state_d = ST_HELD;
            end else if (s != '0) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d     = '0;
               cand_d    = '0;
               key_out_d = '0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            cnt_d     = '0;
            cand_d    = '0;
            key_out_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
      key_valid_d = |key_out_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cand_q      <= '0;
         key_out_q   <= '0;
         key_valid_q <= 1'b0;
         key_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_out_q   <= key_out_d;
         key_valid_q <= key_valid_d;
         key_pulse_q <= key_pulse_d;
      end
   end

   assign key_out   = key_out_q;
   assign key_valid = key_valid_q;
   assign key_pulse = key_pulse_q;

endmodule

// File: tb/tb_key_debounce_onehot.sv
// Directed bench for key_debounce_onehot with a short debounce window; accepted
// presses are scoreboarded as {cycle, key} pairs against the strobe.
module tb_key_debounce_onehot;

   localparam int DEB = 4;
   localparam int LAT = DEB + 3;  // negedge count from drive to visible output

   logic       clk;
   logic       rst_n;
   logic [9:0] btn;
   logic [9:0] key_out;
   logic       key_valid;
   logic       key_pulse;

   int unsigned cyc;
   int          total;
   int          bad;
   logic [41:0] exp_q[$];

   key_debounce_onehot #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn       (btn),
      .key_out   (key_out),
      .key_valid (key_valid),
      .key_pulse (key_pulse)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive a level at the current negedge; a press accepted from here shows up LAT negedges later.
   task automatic press_expect(input logic [9:0] k);
      btn = k;
      exp_q.push_back({32'(cyc + LAT), k});
   endtask

   task automatic check_key_at(input string tag, input int n, input logic [9:0] k);
      tick(n);
      check(tag, {32'b0, key_out}, {32'b0, k});
   endtask

   // scoreboard: every strobe must match the next expected {cycle, key}
   always @(negedge clk) begin
      check("valid_eq_or", {41'b0, key_valid}, {41'b0, |key_out});
      if (key_pulse) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {32'(cyc), key_out}, 42'b0);
         end else begin
            check("pulse", {32'(cyc), key_out}, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [41:0] zero_w;
      zero_w = '0;
      cyc   = 0;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      btn   = 10'h3FF;

      // 1: reset holds everything low, even with all buttons pressed
      repeat (3) begin
         tick(1);
         check("rst_out", {31'b0, key_out, key_valid}, zero_w);
         check("rst_pulse", {41'b0, key_pulse}, zero_w);
      end
      rst_n = 1'b1;
      repeat (2) begin
         tick(1);
         check("post_rst", {30'b0, key_out, key_valid, key_pulse}, zero_w);
      end
      btn = '0;
      tick(4);

      // 2: clean press of key 3, then release
      press_expect(10'b0000001000);
      check_key_at("press3_early", LAT - 1, 10'h000);
      check_key_at("press3_late", 1, 10'b0000001000);
      tick(20 - LAT);
      btn = '0;
      check_key_at("rel3_early", LAT - 1, 10'b0000001000);
      check_key_at("rel3_late", 1, 10'h000);
      tick(4);

      // 3: bounce on key 5 settles into one accepted press
      btn = 10'h020; tick(1);
      btn = 10'h000; tick(1);
      btn = 10'h020; tick(1);
      btn = 10'h020; tick(1);
      btn = 10'h000; tick(1);
      press_expect(10'h020);
      check_key_at("bounce_early", LAT - 1, 10'h000);
      check_key_at("bounce_late", 1, 10'h020);
      btn = '0;
      check_key_at("bounce_rel", LAT + 2, 10'h000);

      // 3b: a 3-cycle glitch never produces a key
      btn = 10'h010;
      tick(3);
      btn = '0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         check("glitch", {32'b0, key_out}, zero_w);
      end

      // 4: two keys together are ignored; dropping one accepts the other
      btn = 10'b0000000011;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("multi", {32'b0, key_out}, zero_w);
      end
      press_expect(10'b0000000001);
      check_key_at("multi_drop_early", LAT - 1, 10'h000);
      check_key_at("multi_drop_late", 1, 10'h001);
      btn = '0;
      check_key_at("multi_rel", LAT + 2, 10'h000);

      // 5: key 9 held, key 2 added on top, then both released
      press_expect(10'h200);
      check_key_at("k9_accept", LAT, 10'h200);
      btn = 10'h204;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("k9_extra", {32'b0, key_out}, {32'b0, 10'h200});
      end
      btn = '0;
      check_key_at("k9_rel_early", LAT - 1, 10'h200);
      check_key_at("k9_rel_late", 1, 10'h000);
      tick(4);

      // 6: async reset pulse while key 7 is held, then re-acceptance
      press_expect(10'h080);
      check_key_at("k7_accept", LAT + 3, 10'h080);
      #1 rst_n = 1'b0;
      #1 check("async_rst", {31'b0, key_out, key_valid}, zero_w);
      rst_n = 1'b1;
      exp_q.push_back({32'(cyc + LAT), 10'h080});
      check_key_at("k7_reaccept_early", LAT - 1, 10'h000);
      check_key_at("k7_reaccept_late", 1, 10'h080);
      btn = '0;
      check_key_at("k7_rel", LAT + 2, 10'h000);

      check("exp_q_drained", 42'(exp_q.size()), zero_w);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
